pe_chain_host: RTL and testbench

//   Host-side initiator for the PE chain. Forwards an upstream stream of (a, b, b_valid) operand words into the first PE

---
 rtl/pe_chain_host_if.sv | 51 +++++
 rtl/pe_chain_host.sv | 122 ++++++++++++
 tb/tb_pe_chain_host.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/pe_chain_host_if.sv
// Bundle of upstream operand stream, PE operand port, PE result-memory port and result stream.
// The host uses the master view; the surrounding environment uses the slave view.
// Widths follow LOG_SIZE so the address bus matches the PE result-memory depth.
interface pe_chain_host_if #(
  parameter int LOG_SIZE = 3
);
  logic [31:0]         in_a;
  logic [31:0]         in_b;
  logic                in_b_valid;
  logic                in_last;
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         pe_a;
  logic [31:0]         pe_b;
  logic                pe_b_valid;
  logic                pe_stb;
  logic                pe_ack;
  logic                pe_done;
  logic [LOG_SIZE-1:0] pe_addr;
  logic                pe_mem_select;
  logic [31:0]         pe_c;
  logic [31:0]         res_data;
  logic                res_valid;
  logic                res_ready;
  logic                res_last;
  logic                busy;

  modport master (
    input  in_a, in_b, in_b_valid, in_last, in_valid,
    output in_ready,
    output pe_a, pe_b, pe_b_valid, pe_stb,
    input  pe_ack, pe_done,
    output pe_addr, pe_mem_select,
    input  pe_c,
    output res_data, res_valid, res_last,
    input  res_ready,
    output busy
  );

  modport slave (
    output in_a, in_b, in_b_valid, in_last, in_valid,
    input  in_ready,
    input  pe_a, pe_b, pe_b_valid, pe_stb,
    output pe_ack, pe_done,
    input  pe_addr, pe_mem_select,
    output pe_c,
    input  res_data, res_valid, res_last,
    output res_ready,
    input  busy
  );
endinterface

// File: rtl/pe_chain_host.sv
// Host initiator for the PE chain: feeds operand words one at a time, waits for done, then reads back 2**LOG_SIZE results.
// Latency: one operand per stb/ack handshake (ack must drop before the next); readout needs at least 3 cycles per result.
// Backpressure: in_ready only in IDLE/IDLE_FEED/WAIT_LOW-with-ack-low; res_data holds while res_valid && !res_ready.
module pe_chain_host #(
  parameter int LOG_SIZE = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  pe_chain_host_if.master  bus
);

  localparam int CW = LOG_SIZE + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'((1 << LOG_SIZE) - 1);

  typedef enum logic [2:0] {
    IDLE, SEND, WAIT_LOW, IDLE_FEED, DRAIN, RD_REQ, RD_CAP, RD_OUT
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   b_q, b_d;
  logic          bv_q, bv_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   res_q, res_d;
  logic          in_ready_c;
  logic          take;

  // Next-state logic; the hold register is only loaded on an accepted upstream word.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    bv_d       = bv_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    res_d      = res_q;
    in_ready_c = 1'b0;
    take       = 1'b0;
    case (state_q)
      IDLE:      in_ready_c = 1'b1;
      SEND:      if (bus.pe_ack) state_d = WAIT_LOW;
      // A still-high ack here is the stale one from the transfer just made.
      WAIT_LOW: begin
        if (!bus.pe_ack) begin
          if (last_q) begin
            state_d = DRAIN;
          end else begin
            in_ready_c = 1'b1;
            state_d    = IDLE_FEED;
          end
        end
      end
      IDLE_FEED: in_ready_c = 1'b1;
      DRAIN: begin
        if (bus.pe_done) begin
          cnt_d   = '0;
          state_d = RD_REQ;
        end
      end
      RD_REQ:    state_d = RD_CAP;
      RD_CAP: begin
        res_d   = bus.pe_c;
        state_d = RD_OUT;
      end
      RD_OUT: begin
        if (bus.res_ready) begin
          if (cnt_q == LAST_IDX) begin
            state_d = IDLE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = RD_REQ;
          end
        end
      end
      default:   state_d = IDLE;
    endcase
    take = in_ready_c & bus.in_valid;
    if (take) begin
      a_d     = bus.in_a;
      b_d     = bus.in_b;
      bv_d    = bus.in_b_valid;
      last_d  = bus.in_last;
      state_d = SEND;
    end
  end

  // State and datapath registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      bv_q    <= 1'b0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      bv_q    <= bv_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  // in_ready is gated by reset so every output reads 0 while rst_n is low.
  assign bus.in_ready      = rst_n & in_ready_c;
  assign bus.pe_a          = a_q;
  assign bus.pe_b          = b_q;
  assign bus.pe_b_valid    = bv_q;
  assign bus.pe_stb        = (state_q == SEND);
  assign bus.pe_mem_select = (state_q == RD_REQ);
  assign bus.pe_addr       = (state_q == RD_REQ) ? cnt_q[LOG_SIZE-1:0] : '0;
  assign bus.res_data      = res_q;
  assign bus.res_valid     = (state_q == RD_OUT);
  assign bus.res_last      = (state_q == RD_OUT) && (cnt_q == LAST_IDX);
  assign bus.busy          = (state_q != IDLE);

endmodule

// File: tb/tb_pe_chain_host.sv
// Bench for pe_chain_host: PE ack/memory model plus directed operand jobs and readouts.
module tb_pe_chain_host;
  localparam int LOG_SIZE = 3;
  localparam int NWORDS   = 1 << LOG_SIZE;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pe_chain_host_if #(.LOG_SIZE(LOG_SIZE)) bus ();
  pe_chain_host #(.LOG_SIZE(LOG_SIZE)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // PE model: after a transfer ack stays high stale_hi cycles, then low low_len cycles.
  int          stale_hi = 1;
  int          low_len  = 2;
  logic        ack_hold_low = 1'b0;
  int          k = 0;
  int          xfer_cnt = 0;
  int          sel_cnt = 0;
  int          clash_cnt = 0;
  logic [31:0] xa [32];
  logic [31:0] xb [32];
  logic        xbv [32];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) k <= 0;
    else if (bus.pe_stb && bus.pe_ack) k <= stale_hi + low_len;
    else if (k != 0) k <= k - 1;
  end
  assign bus.pe_ack = !ack_hold_low && ((k == 0) || (k > low_len));

  always @(posedge clk) begin
    if (bus.pe_stb && bus.pe_ack) begin
      xa[xfer_cnt % 32]  <= bus.pe_a;
      xb[xfer_cnt % 32]  <= bus.pe_b;
      xbv[xfer_cnt % 32] <= bus.pe_b_valid;
      xfer_cnt <= xfer_cnt + 1;
    end
    if (bus.pe_mem_select) begin
      sel_cnt  <= sel_cnt + 1;
      bus.pe_c <= {24'(bus.pe_addr), 8'h00};
    end
    if (bus.pe_stb && bus.pe_mem_select) clash_cnt <= clash_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic bv, input logic last);
    int n = 0;
    bus.in_a = a; bus.in_b = b; bus.in_b_valid = bv; bus.in_last = last; bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL push_accept: in_ready=%b required 1 (a=%h)", bus.in_ready, a);
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic check_words(input int base, input logic [31:0] ea [3], input logic [31:0] eb [3], input logic ebv [3]);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (xa[base+i] !== ea[i] || xb[base+i] !== eb[i] || xbv[base+i] !== ebv[i]) begin
        errors++;
        $display("FAIL xfer_data[%0d]: got a=%h b=%h bv=%b required a=%h b=%h bv=%b",
                 i, xa[base+i], xb[base+i], xbv[base+i], ea[i], eb[i], ebv[i]);
      end
    end
  endtask

  task automatic collect(input int stall_idx);
    int n;
    int s;
    for (int i = 0; i < NWORDS; i++) begin
      n = 0;
      while (!bus.res_valid && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (bus.res_valid !== 1'b1) begin
        errors++; $display("FAIL res_valid[%0d]: got %b required 1", i, bus.res_valid);
      end
      if (i > 0) begin
        checks++;
        if (n != 2) begin errors++; $display("FAIL readout_gap[%0d]: got %0d required 2", i, n); end
      end
      checks++;
      if (bus.res_data !== 32'(i * 256)) begin
        errors++; $display("FAIL res_data[%0d]: got %h required %h", i, bus.res_data, 32'(i * 256));
      end
      checks++;
      if (bus.res_last !== (i == NWORDS - 1)) begin
        errors++; $display("FAIL res_last[%0d]: got %b required %b", i, bus.res_last, (i == NWORDS - 1));
      end
      if (i == stall_idx) begin
        bus.res_ready = 1'b0;
        s = sel_cnt;
        repeat (5) begin
          @(negedge clk);
          checks++;
          if (bus.res_data !== 32'(i * 256) || bus.res_valid !== 1'b1 || bus.pe_mem_select !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold: data=%h valid=%b sel=%b required data=%h valid=1 sel=0",
                     bus.res_data, bus.res_valid, bus.pe_mem_select, 32'(i * 256));
          end
        end
        checks++;
        if (sel_cnt != s) begin errors++; $display("FAIL stall_no_advance: reads=%0d required %0d", sel_cnt, s); end
        bus.res_ready = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL end_idle: busy=%b required 0", bus.busy); end
  endtask

  task automatic test_reset();
    bus.in_a = '0; bus.in_b = '0; bus.in_b_valid = 1'b0; bus.in_last = 1'b0; bus.in_valid = 1'b0;
    bus.pe_done = 1'b0; bus.res_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.in_ready, bus.pe_stb, bus.busy, bus.res_valid, bus.res_last, bus.pe_mem_select} !== 6'b0 ||
        bus.pe_a !== 32'h0 || bus.res_data !== 32'h0) begin
      errors++; $display("FAIL reset_outputs: rdy=%b stb=%b busy=%b vld=%b required all 0",
                         bus.in_ready, bus.pe_stb, bus.busy, bus.res_valid);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle: in_ready=%b busy=%b required 1 0", bus.in_ready, bus.busy);
    end
    @(negedge clk);
    ack_hold_low = 1'b1;
    push(32'h11111111, 32'h22222222, 1'b1, 1'b0);
    checks++;
    if (bus.pe_stb !== 1'b1) begin errors++; $display("FAIL in_send: pe_stb=%b required 1", bus.pe_stb); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.pe_stb, bus.res_valid, bus.in_ready, bus.busy} !== 4'b0) begin
      errors++; $display("FAIL reset_mid_send: stb=%b vld=%b rdy=%b busy=%b required 0000",
                         bus.pe_stb, bus.res_valid, bus.in_ready, bus.busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ack_hold_low = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.pe_stb !== 1'b0) begin
      errors++; $display("FAIL after_reset: busy=%b rdy=%b stb=%b required 0 1 0", bus.busy, bus.in_ready, bus.pe_stb);
    end
    @(negedge clk);
  endtask

  task automatic check_drain(input string tag);
    checks++;
    if ({bus.busy, bus.in_ready, bus.pe_stb, bus.pe_mem_select, bus.res_valid} !== 5'b10000) begin
      errors++; $display("FAIL %s: busy/rdy/stb/sel/vld=%b%b%b%b%b required 10000", tag,
                         bus.busy, bus.in_ready, bus.pe_stb, bus.pe_mem_select, bus.res_valid);
    end
  endtask

  task automatic test_three_words();
    int base;
    logic [31:0] ea [3] = '{32'h3F800000, 32'h40400000, 32'h40A00000};
    logic [31:0] eb [3] = '{32'h40000000, 32'h40800000, 32'h40C00000};
    logic        ebv [3] = '{1'b1, 1'b0, 1'b1};
    stale_hi = 1; low_len = 2;
    base = xfer_cnt;
    for (int i = 0; i < 3; i++) push(ea[i], eb[i], ebv[i], i == 2);
    bus.in_valid = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (xfer_cnt - base != 3) begin errors++; $display("FAIL xfer_count: got %0d required 3", xfer_cnt - base); end
    check_words(base, ea, eb, ebv);
    check_drain("drain_entered");
    bus.in_valid = 1'b0;
  endtask

  task automatic test_readout();
    bus.pe_done = 1'b1;
    collect(-1);
    bus.pe_done = 1'b0;
    checks++;
    if (clash_cnt != 0) begin errors++; $display("FAIL stb_sel_clash: got %0d required 0", clash_cnt); end
  endtask

  task automatic test_ack_hold_and_stall();
    int base;
    int s;
    logic [31:0] ea [3] = '{32'hC0000000, 32'h3F000000, 32'h41200000};
    logic [31:0] eb [3] = '{32'h3E800000, 32'hBF800000, 32'h42C80000};
    logic        ebv [3] = '{1'b0, 1'b1, 1'b1};
    stale_hi = 4; low_len = 2;
    base = xfer_cnt;
    s = sel_cnt;
    push(ea[0], eb[0], ebv[0], 1'b0);
    push(ea[1], eb[1], ebv[1], 1'b0);
    checks++;
    if (xfer_cnt - base != 1) begin errors++; $display("FAIL ack_hold_no_dup: got %0d required 1", xfer_cnt - base); end
    checks++;
    if (bus.pe_stb !== 1'b1) begin errors++; $display("FAIL resend_stb: got %b required 1", bus.pe_stb); end
    bus.pe_done = 1'b1;
    @(negedge clk);
    bus.pe_done = 1'b0;
    push(ea[2], eb[2], ebv[2], 1'b1);
    repeat (12) @(negedge clk);
    checks++;
    if (xfer_cnt - base != 3) begin errors++; $display("FAIL ack_hold_count: got %0d required 3", xfer_cnt - base); end
    check_words(base, ea, eb, ebv);
    check_drain("done_pulse_ignored");
    checks++;
    if (sel_cnt != s) begin errors++; $display("FAIL early_readout: reads=%0d required %0d", sel_cnt, s); end
    bus.pe_done = 1'b1;
    collect(2);
    bus.pe_done = 1'b0;
  endtask

  initial begin
    test_reset();
    test_three_words();
    test_readout();
    test_ack_hold_and_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
